// File: rtl/student_id_scroller.sv
// student_id_scroller: shows a NUM_DISP-wide window of a BCD student ID on
// active-low 7-segment displays and scrolls it one digit per step.
module student_id_scroller #(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned STEP_HZ   = 2,
  parameter int unsigned ID_LEN    = 9,
  parameter int unsigned NUM_DISP  = 6,
  parameter logic [63:0] ID_DIGITS = 64'h0000_0005_1012_7014
) (
  input  logic                  clk_50M,
  input  logic                  reset,
  input  logic                  reset_div,
  input  logic                  pause,
  input  logic                  dir,
  output logic [7*NUM_DISP-1:0] hex,
  output logic                  step_led,
  output logic                  wrap_led
);

  localparam int unsigned DIV   = CLK_HZ / STEP_HZ;
  localparam int unsigned DIV_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int unsigned HEX_W = 7 * NUM_DISP;
  localparam logic [3:0]  LAST  = 4'(ID_LEN - 1);

  // Reject parameter sets the divider and display mapping cannot honour
  if ((CLK_HZ % STEP_HZ) != 0 || DIV < 2) begin : g_bad_div
    $error("student_id_scroller: CLK_HZ must be a multiple of STEP_HZ with ratio >= 2");
  end
  if (ID_LEN < 1 || ID_LEN > 16) begin : g_bad_len
    $error("student_id_scroller: ID_LEN must be 1..16");
  end
  if (NUM_DISP < 1 || NUM_DISP > 6) begin : g_bad_disp
    $error("student_id_scroller: NUM_DISP must be 1..6");
  end

  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       pos;
  logic             tick_c;
  logic             step_c;
  logic [HEX_W-1:0] hex_next;

  assign tick_c = (div_cnt == DIV_W'(DIV - 1));
  assign step_c = tick_c && !pause;

  // Segment pattern for the digit shown on display k at scroll position p
  function automatic logic [6:0] seg_for(input logic [3:0] p, input int unsigned k);
    logic [4:0] sum;
    logic [3:0] idx;
    logic [3:0] digit;
    logic [6:0] seg;
    sum   = 5'(p) + 5'(NUM_DISP - 1 - k);
    idx   = 4'(sum % 5'(ID_LEN));
    digit = 4'(ID_DIGITS >> {idx, 2'b00});
    case (digit)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  // Step divider: free-running regardless of pause, restartable by reset_div
  always_ff @(posedge clk_50M) begin
    if (reset || reset_div) begin
      div_cnt <= '0;
    end else if (tick_c) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Scroll position and step/wrap indicators, advanced on accepted steps
  always_ff @(posedge clk_50M) begin
    if (reset) begin
      pos      <= '0;
      step_led <= 1'b0;
      wrap_led <= 1'b0;
    end else if (step_c) begin
      step_led <= ~step_led;
      if (!dir) begin
        if (pos == LAST) begin
          pos      <= '0;
          wrap_led <= ~wrap_led;
        end else begin
          pos <= pos + 4'd1;
        end
      end else begin
        if (pos == 4'd0) begin
          pos      <= LAST;
          wrap_led <= ~wrap_led;
        end else begin
          pos <= pos - 4'd1;
        end
      end
    end
  end

  // Display frame for the current position
  always_comb begin
    hex_next = '1;
    for (int unsigned k = 0; k < NUM_DISP; k++) begin
      hex_next[7*k +: 7] = seg_for(pos, k);
    end
  end

  // Registered segment outputs, blank while in reset
  always_ff @(posedge clk_50M) begin
    if (reset) begin
      hex <= '1;
    end else begin
      hex <= hex_next;
    end
  end

endmodule

// File: tb/tb_student_id_scroller.sv
// Directed bench for student_id_scroller with DIV=4; a second instance
// holds a 3-digit ID containing a non-BCD digit.
module tb_student_id_scroller;

  localparam int unsigned NUM_DISP = 6;
  localparam int unsigned HW       = 7 * NUM_DISP;

  localparam logic [HW-1:0] BLANK  = '1;
  localparam logic [HW-1:0] F_POS0 = {7'h19, 7'h79, 7'h40, 7'h78, 7'h24, 7'h79};
  localparam logic [HW-1:0] F_POS1 = {7'h79, 7'h40, 7'h78, 7'h24, 7'h79, 7'h40};
  localparam logic [HW-1:0] F_POS3 = {7'h78, 7'h24, 7'h79, 7'h40, 7'h79, 7'h12};
  localparam logic [HW-1:0] F_POS5 = {7'h79, 7'h40, 7'h79, 7'h12, 7'h19, 7'h79};
  localparam logic [HW-1:0] F_POS7 = {7'h79, 7'h12, 7'h19, 7'h79, 7'h40, 7'h78};
  localparam logic [HW-1:0] F_POS8 = {7'h12, 7'h19, 7'h79, 7'h40, 7'h78, 7'h24};
  localparam logic [HW-1:0] S_POS0 = {7'h79, 7'h24, 7'h7F, 7'h79, 7'h24, 7'h7F};
  localparam logic [HW-1:0] S_POS1 = {7'h24, 7'h7F, 7'h79, 7'h24, 7'h7F, 7'h79};

  logic          clk = 1'b0;
  logic          reset, reset_div, pause, dir;
  logic [HW-1:0] hex, hex_s;
  logic          step_led, wrap_led, step_s, wrap_s;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  student_id_scroller #(
    .CLK_HZ(8), .STEP_HZ(2), .ID_LEN(9), .NUM_DISP(NUM_DISP),
    .ID_DIGITS(64'h0000_0005_1012_7014)
  ) u_dut (
    .clk_50M(clk), .reset(reset), .reset_div(reset_div), .pause(pause), .dir(dir),
    .hex(hex), .step_led(step_led), .wrap_led(wrap_led)
  );

  student_id_scroller #(
    .CLK_HZ(8), .STEP_HZ(2), .ID_LEN(3), .NUM_DISP(NUM_DISP),
    .ID_DIGITS(64'h0000_0000_0000_0A21)
  ) u_short (
    .clk_50M(clk), .reset(reset), .reset_div(reset_div), .pause(pause), .dir(dir),
    .hex(hex_s), .step_led(step_s), .wrap_led(wrap_s)
  );

  // Count one comparison and report it if it does not hold
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n clock edges and settle just after the last one
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    reset_div = 1'b0;
    pause     = 1'b0;
    dir       = 1'b0;

    // Reset and first frame
    cyc(2);
    check("hex_in_reset", 64'(hex), 64'(BLANK));
    check("short_hex_in_reset", 64'(hex_s), 64'(BLANK));
    reset = 1'b0;
    cyc(1);
    check("first_frame", 64'(hex), 64'(F_POS0));
    check("first_step_led", 64'(step_led), 64'd0);
    check("first_wrap_led", 64'(wrap_led), 64'd0);
    check("short_first_frame", 64'(hex_s), 64'(S_POS0));

    // Forward scroll: first step lands DIV edges after release
    cyc(3);
    check("fwd_t1_step_led", 64'(step_led), 64'd1);
    check("fwd_t1_hex5_latency", 64'(hex[41:35]), 64'h19);
    cyc(1);
    check("fwd_t1_hex5", 64'(hex[41:35]), 64'h79);
    check("fwd_t1_frame", 64'(hex), 64'(F_POS1));
    check("short_t1_frame", 64'(hex_s), 64'(S_POS1));
    check("short_t1_wrap", 64'(wrap_s), 64'd0);
    for (int k = 2; k <= 8; k++) begin
      cyc(4);
      if (k == 3) begin
        check("short_t3_wrap", 64'(wrap_s), 64'd1);
        check("short_t3_frame", 64'(hex_s), 64'(S_POS0));
      end
    end
    check("fwd_t8_frame", 64'(hex), 64'(F_POS8));
    check("fwd_t8_wrap_led", 64'(wrap_led), 64'd0);
    check("fwd_t8_step_led", 64'(step_led), 64'd0);
    cyc(4);
    check("fwd_t9_frame", 64'(hex), 64'(F_POS0));
    check("fwd_t9_wrap_led", 64'(wrap_led), 64'd1);
    check("fwd_t9_step_led", 64'(step_led), 64'd1);

    // Backward wrap from reset
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    dir   = 1'b1;
    cyc(4);
    check("bwd_wrap_led", 64'(wrap_led), 64'd1);
    check("bwd_step_led", 64'(step_led), 64'd1);
    cyc(1);
    check("bwd_hex5", 64'(hex[41:35]), 64'h12);
    check("bwd_hex4", 64'(hex[34:28]), 64'h19);
    check("bwd_frame", 64'(hex), 64'(F_POS8));

    // Pause across three ticks
    pause = 1'b1;
    cyc(12);
    check("pause_frame", 64'(hex), 64'(F_POS8));
    check("pause_step_led", 64'(step_led), 64'd1);
    check("pause_wrap_led", 64'(wrap_led), 64'd1);
    pause = 1'b0;
    cyc(3);
    check("resume_step_led", 64'(step_led), 64'd0);
    check("resume_wrap_led", 64'(wrap_led), 64'd1);
    cyc(1);
    check("resume_frame", 64'(hex), 64'(F_POS7));
    cyc(2);
    check("spacing_before", 64'(step_led), 64'd0);
    cyc(1);
    check("spacing_at", 64'(step_led), 64'd1);

    // reset_div pulse with div_cnt at 2 delays the next tick
    cyc(2);
    reset_div = 1'b1;
    cyc(1);
    reset_div = 1'b0;
    cyc(1);
    check("rdiv_no_early_tick", 64'(step_led), 64'd1);
    cyc(2);
    check("rdiv_still_waiting", 64'(step_led), 64'd1);
    check("rdiv_wrap_kept", 64'(wrap_led), 64'd1);
    cyc(1);
    check("rdiv_late_tick", 64'(step_led), 64'd0);
    cyc(1);
    check("rdiv_frame", 64'(hex), 64'(F_POS5));

    // reset_div in a tick cycle: step still happens, count restarts
    cyc(2);
    reset_div = 1'b1;
    cyc(1);
    reset_div = 1'b0;
    check("rdiv_tick_step", 64'(step_led), 64'd1);
    cyc(3);
    check("rdiv_tick_gap", 64'(step_led), 64'd1);
    cyc(1);
    check("rdiv_tick_next", 64'(step_led), 64'd0);
    cyc(1);
    check("rdiv_tick_frame", 64'(hex), 64'(F_POS3));

    // reset together with reset_div and pause acts as plain reset
    reset     = 1'b1;
    reset_div = 1'b1;
    pause     = 1'b1;
    cyc(1);
    check("rst_rdiv_hex", 64'(hex), 64'(BLANK));
    check("rst_rdiv_step_led", 64'(step_led), 64'd0);
    check("rst_rdiv_wrap_led", 64'(wrap_led), 64'd0);
    reset     = 1'b0;
    reset_div = 1'b0;
    pause     = 1'b0;
    cyc(1);
    check("rst_rdiv_frame", 64'(hex), 64'(F_POS0));

    // Held reset_div suppresses ticks
    reset_div = 1'b1;
    cyc(10);
    check("held_rdiv_step_led", 64'(step_led), 64'd0);
    reset_div = 1'b0;
    cyc(3);
    check("held_rdiv_release_gap", 64'(step_led), 64'd0);
    cyc(1);
    check("held_rdiv_first_step", 64'(step_led), 64'd1);
    check("held_rdiv_wrap_led", 64'(wrap_led), 64'd1);
    cyc(1);
    check("held_rdiv_frame", 64'(hex), 64'(F_POS8));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
